// File: rtl/mem_arbiter_if.sv
// Bundle of the pipeline request/response signals and the byte-wide memory port
// shared by the mem_arbiter and whatever drives it.
interface mem_arbiter_if #(
  parameter int unsigned AW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [15:0]   if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [15:0]   d_wdata;
  logic          d_done;
  logic [15:0]   d_rdata;

  logic [AW-1:0] mem_raddr;
  logic [7:0]    mem_rdata;
  logic          mem_wen;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;

  logic          busy;

  // Requesters plus memory array side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_done, if_rdata, d_done, d_rdata, mem_raddr, mem_wen, mem_waddr, mem_wdata, busy
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_done, if_rdata, d_done, d_rdata, mem_raddr, mem_wen, mem_waddr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter that splits 16-bit big-endian accesses into two byte accesses.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed data-over-fetch.
module mem_arbiter #(
  parameter int unsigned AW = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StB0, StB1, StResp} state_e;

  state_e        state_q, state_d;
  logic          any_req;
  logic          grant_data;
  logic          own_data_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_inc;
  logic [15:0]   wdata_q;
  logic [7:0]    hi_q;
  logic [15:0]   if_rdata_q;
  logic [15:0]   d_rdata_q;
`ifdef MEM_ARB_RR_EN
  logic          last_data_q;
`endif

  assign any_req  = bus_io.if_req | bus_io.d_req;
  assign addr_inc = addr_q + AW'(1);

  always_comb begin
`ifdef MEM_ARB_RR_EN
    // On a tie, hand the grant to whoever did not win last time.
    grant_data = bus_io.d_req & (~bus_io.if_req | ~last_data_q);
`else
    grant_data = bus_io.d_req;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StB0;
      StB0:    state_d = StB1;
      StB1:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_data_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 16'h0000;
      hi_q        <= 8'h00;
      if_rdata_q  <= 16'h0000;
      d_rdata_q   <= 16'h0000;
`ifdef MEM_ARB_RR_EN
      last_data_q <= 1'b1;
`endif
    end else begin
      if (state_q == StIdle && any_req) begin
        own_data_q  <= grant_data;
        addr_q      <= grant_data ? bus_io.d_addr : bus_io.if_addr;
        // A fetch never writes, whatever d_we says.
        we_q        <= grant_data & bus_io.d_we;
        wdata_q     <= bus_io.d_wdata;
`ifdef MEM_ARB_RR_EN
        last_data_q <= grant_data;
`endif
      end
      if (state_q == StB0 && !we_q) begin
        hi_q <= bus_io.mem_rdata;
      end
      if (state_q == StB1 && !we_q) begin
        if (own_data_q) begin
          d_rdata_q <= {hi_q, bus_io.mem_rdata};
        end else begin
          if_rdata_q <= {hi_q, bus_io.mem_rdata};
        end
      end
    end
  end

  always_comb begin
    bus_io.mem_raddr = '0;
    bus_io.mem_waddr = '0;
    bus_io.mem_wen   = 1'b0;
    bus_io.mem_wdata = 8'h00;
    bus_io.if_done   = 1'b0;
    bus_io.d_done    = 1'b0;
    bus_io.busy      = (state_q != StIdle);
    bus_io.if_rdata  = if_rdata_q;
    bus_io.d_rdata   = d_rdata_q;
    unique case (state_q)
      StB0: begin
        bus_io.mem_raddr = addr_q;
        bus_io.mem_waddr = addr_q;
        bus_io.mem_wen   = we_q;
        bus_io.mem_wdata = we_q ? wdata_q[15:8] : 8'h00;
      end
      StB1: begin
        bus_io.mem_raddr = addr_inc;
        bus_io.mem_waddr = addr_inc;
        bus_io.mem_wen   = we_q;
        bus_io.mem_wdata = we_q ? wdata_q[7:0] : 8'h00;
      end
      StResp: begin
        bus_io.if_done = ~own_data_q;
        bus_io.d_done  = own_data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester controller for the shared byte-wide memory (one combinational read port, one clocked write port). Serialises 16-bit big-endian instruction fetches and data loads/stores from the pipeline into two byte accesses each, arbitrates between fetch and data, and returns completed words with a one-cycle done pulse. Sits between the fetch/memory stages and the memory array.

## Interface
- AW, 16, address width (memory and requester addresses)
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request (read only)
- if_addr  in  AW  fetch word address (byte address of high byte)
- if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  16  fetched word, held until next fetch completes
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data word address
- d_wdata  in  16  store data
- d_done  out  1  one-cycle pulse: data access complete
- d_rdata  out  16  load word, held until next load completes
- mem_raddr  out  AW  memory read address
- mem_rdata  in  8  memory read data (combinational from mem_raddr)
- mem_wen  out  1  memory write enable
- mem_waddr  out  AW  memory write address
- mem_wdata  out  8  memory write data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, B0, B1, RESP. Reset -> IDLE.
- IDLE: if any req high, grant one, latch owner, addr, we, wdata; -> B0. Else stay.
- B0: mem_raddr = mem_waddr = addr. Load/fetch: capture mem_rdata into word[15:8] at clock edge. Store: mem_wen = 1, mem_wdata = wdata[15:8]. -> B1.
- B1: addresses = addr + 1, modulo 2^AW (16'hFFFF wraps to 16'h0000). Load/fetch: capture word[7:0]. Store: mem_wen = 1, mem_wdata = wdata[7:0]. -> RESP.
- RESP: pulse owner's done; for reads, owner's rdata register updated at the B1->RESP edge; non-owner outputs unchanged. -> IDLE.
- Fetch is never a write, regardless of d_we.
- Requests are sampled only in IDLE; req/addr/wdata changes after grant are ignored.
- A req still high in the IDLE cycle after done is a new transaction; requesters drop req in the cycle done is seen if no further access wanted.
- Default arbitration (fixed): data wins over fetch when both high.
- Outside B0/B1: mem_wen = 0, mem_raddr = mem_waddr = 0, mem_wdata = 0.
- Outputs are decoded only from registers (no req-to-mem combinational path).

## Timing
- Request high in IDLE at cycle N -> B0 at N+1, B1 at N+2, done high at N+3, next grant earliest N+4 (4-cycle throughput).
- Store bytes written at posedges ending N+1 (addr) and N+2 (addr+1).
- Reset values: state IDLE; if_done, d_done, busy, mem_wen 0; if_rdata, d_rdata 16'h0000; all mem address/data outputs 0; RR pointer = "data last".
- Reset asserted mid-transaction: immediate return to IDLE, no done pulse; a store interrupted after B0 leaves only the high byte written (accepted, documented).

## Configuration
- MEM_ARB_RR_EN defined: round-robin; on simultaneous requests grant the requester not granted most recently; pointer updates at each grant; after reset fetch wins first tie.
- Undefined: fixed priority data > fetch; fetch can starve under continuous data requests.
- Single-requester behaviour identical in both builds.

## Test plan
- Fetch only: mem[0x0010]=0xAB, mem[0x0011]=0xCD, if_req@0x0010 -> if_done at N+3, if_rdata=0xABCD, d_done stays 0.
- Store then load: d_we=1, d_addr=0x2000, d_wdata=0x1234 -> mem[0x2000]=0x12, mem[0x2001]=0x34, d_done N+3; load 0x2000 -> d_rdata=0x1234.
- Wrap: store 0xBEEF at 0xFFFF -> mem[0xFFFF]=0xBE, mem[0x0000]=0xEF.
- Contention: if_req and d_req both held high from reset -> fixed build: data, data, ... fetch never granted; MEM_ARB_RR_EN build: fetch, data, fetch, data, done pulses 4 cycles apart.
- Reset mid-store: assert rst_n=0 during B1 of store 0x5566 at 0x3000 -> mem[0x3000]=0x55, mem[0x3001] unchanged, no d_done, all outputs at reset values.
- Stability: change d_addr/d_wdata during B0 -> access uses values latched at grant.
